// File: rtl/fifo_read_engine.sv
// ---------------------------------------------------------------------------
// fifo_read_engine
//   Read-side controller for the async FIFO, living entirely in the rclk
//   domain. Pops words from a first-word-fall-through FIFO into a small
//   shift-register output buffer and hands them downstream on valid/ready.
//   MODE=0 streams while en is high; MODE=1 pops exactly BURST_LEN words per
//   start pulse and flags the final word with rd_last / burst_done.
//
// Ports
//   rclk, Rrst   read clock, asynchronous active-high reset
//   rdata        FIFO head word (valid when rempty=0)
//   rempty       FIFO empty flag
//   rinc         FIFO pop strobe (combinational)
//   en           stream enable level (MODE=0 only)
//   start        burst request, sampled only while idle (MODE=1 only)
//   rd_valid     rd_data holds a valid word
//   rd_ready     downstream accepts rd_data this cycle
//   rd_data      head word of the output buffer
//   rd_last      head word is the final word of a burst
//   burst_done   one-cycle pulse after the last burst word is accepted
//   busy         controller active or buffer still holding words
//   rd_words     running count of accepted words (wraps)
// ---------------------------------------------------------------------------
module fifo_read_engine #(
  parameter int DATA_W     = 16,
  parameter int SKID_DEPTH = 2,
  parameter int MODE       = 0,
  parameter int BURST_LEN  = 4,
  parameter int CNT_W      = 16
) (
  input  logic              rclk,
  input  logic              Rrst,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rempty,
  output logic              rinc,
  input  logic              en,
  input  logic              start,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              burst_done,
  output logic              busy,
  output logic [CNT_W-1:0]  rd_words
);

  localparam int OCC_W = $clog2(SKID_DEPTH + 1);

  localparam logic [OCC_W-1:0] DEPTH_C     = OCC_W'(SKID_DEPTH);
  localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_BURST  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [DATA_W-1:0] data_q [SKID_DEPTH];
  logic [DATA_W-1:0] data_d [SKID_DEPTH];
  logic              last_q [SKID_DEPTH];
  logic              last_d [SKID_DEPTH];
  logic              done_q, done_d;
  logic [CNT_W-1:0]  words_q, words_d;

  logic              accept;
  logic              popLast;
  logic [OCC_W-1:0]  writeIdx;

  assign rd_valid   = (occ_q != '0);
  assign accept     = rd_valid & rd_ready;
  assign rd_data    = data_q[0];
  assign rd_last    = last_q[0];
  assign burst_done = done_q;
  assign rd_words   = words_q;
  assign busy       = (state_q != ST_IDLE) || (occ_q != '0);

  // Pop only while the buffer has a free slot, so a full buffer throttles the
  // FIFO without ever dropping a word.
  assign rinc = ((state_q == ST_STREAM) ||
                 ((state_q == ST_BURST) && (remain_q != '0))) &&
                !rempty && (occ_q < DEPTH_C);

  // The word taken while remaining goes 1 -> 0 closes the burst.
  assign popLast = (state_q == ST_BURST) && (remain_q == CNT_W'(1));

  // A simultaneous accept shifts the buffer down one slot, so the new word
  // lands one position lower than the current occupancy.
  assign writeIdx = accept ? (occ_q - 1'b1) : occ_q;

  always_comb begin
    data_d = data_q;
    last_d = last_q;
    occ_d  = occ_q;
    if (accept) begin
      for (int i = 0; i < SKID_DEPTH - 1; i++) begin
        data_d[i] = data_q[i+1];
        last_d[i] = last_q[i+1];
      end
    end
    if (rinc) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        if (OCC_W'(i) == writeIdx) begin
          data_d[i] = rdata;
          last_d[i] = popLast;
        end
      end
    end
    if (rinc && !accept) begin
      occ_d = occ_q + 1'b1;
    end else if (!rinc && accept) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    case (state_q)
      ST_IDLE: begin
        if ((MODE == 0) && en) begin
          state_d = ST_STREAM;
        end else if ((MODE != 0) && start) begin
          state_d  = ST_BURST;
          remain_d = BURST_LEN_C;
        end
      end
      ST_STREAM: begin
        if (!en) begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (remain_q == '0) begin
          state_d = ST_IDLE;
        end else if (rinc) begin
          remain_d = remain_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign done_d  = accept && last_q[0];
  assign words_d = accept ? (words_q + 1'b1) : words_q;

  always_ff @(posedge rclk or posedge Rrst) begin
    if (Rrst) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
      occ_q    <= '0;
      done_q   <= 1'b0;
      words_q  <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      occ_q    <= occ_d;
      done_q   <= done_d;
      words_q  <= words_d;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        data_q[i] <= data_d[i];
        last_q[i] <= last_d[i];
      end
    end
  end

endmodule
